// File: rtl/button_conditioner_pkg.sv
// Shared thermostat package: repeat-FSM state encoding, default button
// timing constants and a counter-width helper.
package thermo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  // Defaults assume a 100 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES      = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 20_000_000;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the thermostat: raw levels in,
// conditioned one-cycle pulses out.
interface button_conditioner_if;

  logic Set_raw;
  logic Up_raw;
  logic Down_raw;
  logic Set_pulse;
  logic Up_pulse;
  logic Down_pulse;

  // Pin side drives the raw levels and consumes the pulses.
  modport master (
    output Set_raw, Up_raw, Down_raw,
    input  Set_pulse, Up_pulse, Down_pulse
  );

  // Conditioner side.
  modport slave (
    input  Set_raw, Up_raw, Down_raw,
    output Set_pulse, Up_pulse, Down_pulse
  );

endinterface

// File: rtl/button_conditioner_debounce.sv
// button_debounce: 2-flop synchroniser, debounce counter and registered
// press pulse for one raw push-button. `rise` is the combinational
// "stable is about to go 0->1" condition so a downstream FSM can act on the
// same edge that the press pulse is registered.
module button_debounce
  import thermo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic Reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          flip;

  // Stable level flips once s2 has disagreed for DEBOUNCE_CYCLES edges.
  assign flip = (s2 != stable) && (cnt == CNT_LAST);
  assign rise = flip && s2;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: count disagreement, restart on any agreement, never wraps.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (flip) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle press pulse on the 0->1 transition of the stable level.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pulse <= 1'b0;
    end else begin
      pulse <= rise;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions the Set/Up/Down push-buttons for the
// thermostat. Each button is synchronised, debounced and turned into a
// single press pulse. Build macro BUTTON_AUTO_REPEAT_EN adds auto-repeat on
// held Up/Down buttons; without it Up/Down behave exactly like Set.
module button_conditioner
  import thermo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input logic                 clk,
  input logic                 Reset,
  button_conditioner_if.slave btn
);

  logic set_stable, set_rise, set_press;
  logic up_stable, up_rise, up_press;
  logic down_stable, down_rise, down_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk), .Reset(Reset), .raw(btn.Set_raw),
    .stable(set_stable), .rise(set_rise), .pulse(set_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .Reset(Reset), .raw(btn.Up_raw),
    .stable(up_stable), .rise(up_rise), .pulse(up_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .Reset(Reset), .raw(btn.Down_raw),
    .stable(down_stable), .rise(down_rise), .pulse(down_press)
  );

  // Set never repeats, so its level and rise strobe are not needed.
  logic unused_set;
  assign unused_set = set_stable ^ set_rise;

  assign btn.Set_pulse = set_press;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW = cnt_width(RMAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

  // Channel 0 = Up, channel 1 = Down.
  logic [1:0]    rep_stable;
  logic [1:0]    rep_rise;
  logic [1:0]    rep_pulse;
  logic [1:0]    rep_pulse_nx;
  repeat_state_t rep_state    [2];
  repeat_state_t rep_state_nx [2];
  logic [RW-1:0] rcnt         [2];
  logic [RW-1:0] rcnt_nx      [2];
  logic          both_held;

  assign rep_stable = {down_stable, up_stable};
  assign rep_rise   = {down_rise, up_rise};
  // Up and Down held together is ambiguous: freeze both repeat timers.
  assign both_held  = &rep_stable;

  // Repeat FSM next state: press starts the delay, release aborts, timers step.
  always_comb begin
    rep_pulse_nx = '0;
    for (int i = 0; i < 2; i++) begin
      rep_state_nx[i] = rep_state[i];
      rcnt_nx[i]      = rcnt[i];
      if (rep_rise[i]) begin
        rep_state_nx[i] = DELAY;
        rcnt_nx[i]      = '0;
      end else if (!rep_stable[i]) begin
        rep_state_nx[i] = IDLE;
        rcnt_nx[i]      = '0;
      end else if (!both_held) begin
        case (rep_state[i])
          DELAY: begin
            if (rcnt[i] == DELAY_LAST) begin
              rep_pulse_nx[i] = 1'b1;
              rcnt_nx[i]      = '0;
              rep_state_nx[i] = REPEAT;
            end else begin
              rcnt_nx[i] = rcnt[i] + RW'(1);
            end
          end
          REPEAT: begin
            if (rcnt[i] == PERIOD_LAST) begin
              rep_pulse_nx[i] = 1'b1;
              rcnt_nx[i]      = '0;
            end else begin
              rcnt_nx[i] = rcnt[i] + RW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Repeat FSM state, timer and registered repeat pulse.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 2; i++) begin
        rep_state[i] <= IDLE;
        rcnt[i]      <= '0;
      end
      rep_pulse <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_state[i] <= rep_state_nx[i];
        rcnt[i]      <= rcnt_nx[i];
      end
      rep_pulse <= rep_pulse_nx;
    end
  end

  assign btn.Up_pulse   = up_press   | rep_pulse[0];
  assign btn.Down_pulse = down_press | rep_pulse[1];
`else
  // Without auto-repeat the debounced levels are not needed downstream.
  logic unused_repeat;
  assign unused_repeat = ^{up_stable, up_rise, down_stable, down_rise};

  assign btn.Up_pulse   = up_press;
  assign btn.Down_pulse = down_press;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5. Expectations follow the
// BUTTON_AUTO_REPEAT_EN build setting. Bit k of a capture vector is the
// pulse value sampled just after edge k, edge 0 being where raw rises.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  button_conditioner_if bif();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_PERIOD_CYCLES(5)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .btn(bif)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] vs, vu, vd;

  localparam logic [63:0] NONE = 64'd0;
  localparam logic [63:0] P6   = 64'd1 << 6;

  // Raise selected buttons at edge 0, release each at its own edge, record pulses.
  task automatic run_window(input int n, input int rel_s, input int rel_u, input int rel_d);
    vs = '0; vu = '0; vd = '0;
    @(posedge clk); #1;
    if (rel_s > 0) bif.Set_raw  = 1'b1;
    if (rel_u > 0) bif.Up_raw   = 1'b1;
    if (rel_d > 0) bif.Down_raw = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      vs[k] = bif.Set_pulse;
      vu[k] = bif.Up_pulse;
      vd[k] = bif.Down_pulse;
      if (k == rel_s) bif.Set_raw  = 1'b0;
      if (k == rel_u) bif.Up_raw   = 1'b0;
      if (k == rel_d) bif.Down_raw = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    bif.Set_raw = 1'b0; bif.Up_raw = 1'b0; bif.Down_raw = 1'b0;
    #2 Reset = 1'b0;
    #20;
    total++; if (bif.Set_pulse !== 1'b0) begin bad++; $display("FAIL reset_set got=%b want=0", bif.Set_pulse); end
    total++; if (bif.Up_pulse !== 1'b0) begin bad++; $display("FAIL reset_up got=%b want=0", bif.Up_pulse); end
    total++; if (bif.Down_pulse !== 1'b0) begin bad++; $display("FAIL reset_down got=%b want=0", bif.Down_pulse); end
    @(posedge clk); #1;
    Reset = 1'b1;
    idle(4);
  endtask

  task automatic test_single_press;
    run_window(24, 0, 8, 0);
    total++; if (vu !== P6) begin bad++; $display("FAIL single_up got=%h want=%h", vu, P6); end
    total++; if (vs !== NONE) begin bad++; $display("FAIL single_set got=%h want=%h", vs, NONE); end
    total++; if (vd !== NONE) begin bad++; $display("FAIL single_down got=%h want=%h", vd, NONE); end
    idle(4);
  endtask

  task automatic test_glitch;
    run_window(16, 3, 0, 0);
    total++; if (vs !== NONE) begin bad++; $display("FAIL glitch3_set got=%h want=%h", vs, NONE); end
    idle(4);
    run_window(16, 4, 0, 0);
    total++; if (vs !== P6) begin bad++; $display("FAIL glitch4_set got=%h want=%h", vs, P6); end
    idle(4);
  endtask

  task automatic test_auto_repeat;
    logic [63:0] exp_d;
`ifdef BUTTON_AUTO_REPEAT_EN
    exp_d = P6 | (64'd1 << 16) | (64'd1 << 21) | (64'd1 << 26) | (64'd1 << 31) | (64'd1 << 36);
`else
    exp_d = P6;
`endif
    run_window(60, 0, 0, 34);
    total++; if (vd !== exp_d) begin bad++; $display("FAIL repeat_down got=%h want=%h", vd, exp_d); end
    total++; if (vu !== NONE) begin bad++; $display("FAIL repeat_up_quiet got=%h want=%h", vu, NONE); end
    idle(4);
  endtask

  task automatic test_both_held;
    logic [63:0] exp_u;
`ifdef BUTTON_AUTO_REPEAT_EN
    exp_u = P6 | (64'd1 << 36) | (64'd1 << 41) | (64'd1 << 46) | (64'd1 << 51);
`else
    exp_u = P6;
`endif
    run_window(62, 0, 48, 20);
    total++; if (vu !== exp_u) begin bad++; $display("FAIL both_up got=%h want=%h", vu, exp_u); end
    total++; if (vd !== P6) begin bad++; $display("FAIL both_down got=%h want=%h", vd, P6); end
    total++; if (vs !== NONE) begin bad++; $display("FAIL both_set got=%h want=%h", vs, NONE); end
    idle(4);
  endtask

  task automatic test_reset_mid_delay;
    logic [63:0] exp_u;
`ifdef BUTTON_AUTO_REPEAT_EN
    exp_u = P6 | (64'd1 << 16) | (64'd1 << 21);
`else
    exp_u = P6;
`endif
    @(posedge clk); #1;
    bif.Up_raw = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++; if (bif.Up_pulse !== 1'b1) begin bad++; $display("FAIL pre_reset_press got=%b want=1", bif.Up_pulse); end
    Reset = 1'b0;
    #1;
    total++; if (bif.Up_pulse !== 1'b0) begin bad++; $display("FAIL async_reset_pulse got=%b want=0", bif.Up_pulse); end
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b1;
    vu = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      vu[k] = bif.Up_pulse;
      if (k == 19) bif.Up_raw = 1'b0;
    end
    total++; if (vu !== exp_u) begin bad++; $display("FAIL after_reset_up got=%h want=%h", vu, exp_u); end
    idle(4);
  endtask

  task automatic test_simultaneous;
    run_window(24, 8, 8, 8);
    total++; if (vs !== P6) begin bad++; $display("FAIL simul_set got=%h want=%h", vs, P6); end
    total++; if (vu !== P6) begin bad++; $display("FAIL simul_up got=%h want=%h", vu, P6); end
    total++; if (vd !== P6) begin bad++; $display("FAIL simul_down got=%h want=%h", vd, P6); end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_auto_repeat();
    test_both_held();
    test_reset_mid_delay();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
